wave_display_render: RTL and testbench
======================================

# wave_display_render

Downstream consumer of the double-buffered waveform sample RAM that the capture stage fills. Each VGA pixel's (x, y) position is turned into a RAM read of the displayed half-buffer. The block outputs a registered pixel colour that draws a connected trace between adjacent samples. It generates `wave_display_idle`, which tells the capture stage when it may swap buffers.

## Interface
Parameters:
- `X_START`, default 11'd256: first pixel column of the 512-px-wide waveform window.
- `TRACE_RGB`, default 24'hFFFFFF: trace colour {r,g,b}; background is 24'h000000.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high.
- `x`  in  11  current VGA column.
- `y`  in  10  current VGA row.
- `valid`  in  1  VGA pixel coordinates are valid this cycle.
- `read_index`  in  1  half-buffer the capture stage has released for display.
- `read_value`  in  8  RAM data; valid 1 cycle after `read_address`; offset binary, 0 = most negative.
- `read_address`  out  9  RAM read address {display_half, sample_idx}.
- `valid_pixel`  out  1  `r`/`g`/`b` are valid.
- `r`, `g`, `b`  out  8 each  pixel colour.
- `wave_display_idle`  out  1  high while the raster is outside the waveform rows.

## Operation
- **Window.** `in_win` = `valid` && `x` in [X_START, X_START+511] && `y` < 512.
- **Sample index.** `sample_idx` = (`x` − X_START)[8:1], so each sample spans 2 columns (0..255).
- **Vertical mapping.** Pixel row `ry` = `y`[8:1]. Plotted row of sample s = 8'd255 − s, so the largest value is at the top.
- **Buffer latch.**
  - `display_half` is a register that loads `read_index` only when `valid` && `y` == 0 && `x` == 0, at frame start.
  - `read_address` = {`display_half`, `sample_idx`}.
  - A buffer swap mid-frame never tears the frame.
- **Line FSM.** Three states, evaluated on cycles with `valid` high:
  - **OUTSIDE.** Entered at reset and whenever `in_win` is 0. Moves to FIRST when `in_win` rises.
  - **FIRST.** First sample of the row. Captures `prev_s` = `curr_s` = `read_value` when it arrives. Moves to DRAW.
  - **DRAW.** When the pipelined `sample_idx` changes, `prev_s` ← `curr_s` and `curr_s` ← `read_value`. Returns to OUTSIDE when `in_win` falls.
- **Draw rule.** The pixel is lit iff the stage-2 state is not OUTSIDE and `ry` lies in [min(p,c), max(p,c)] inclusive, where p = 255 − `prev_s` and c = 255 − `curr_s`. Use an 8-bit unsigned compare; no wrap is possible.
- **Outside the window.** Pixels with `valid` high but outside the window are black. `valid_pixel` follows `valid` regardless of window.
- **Idle output.** `wave_display_idle` is a registered copy of `y`[9] (rows 512..1023), sampled every cycle; it does not depend on `valid`.

## Timing
- Stage 0 (cycle t): `x`/`y`/`valid` in; `read_address` is combinational from stage-0 `x` and the registered `display_half`.
- Stage 1 (t+1): `read_value` arrives; `x`/`y`/`valid`/`in_win` are registered alongside it.
- Stage 2 (t+2): `r`/`g`/`b`/`valid_pixel` are registered. Total latency from coordinates to pixel is exactly 2 cycles.
- Reset values:
  - `r`/`g`/`b` = 0, `valid_pixel` = 0.
  - `wave_display_idle` = 1, `display_half` = 0.
  - FSM = OUTSIDE, `prev_s` = `curr_s` = 8'd128.
- Reset asserted mid-frame: outputs reach their reset values on the next edge. Drawing resumes at the next window entry and uses `display_half` = 0 until the next frame start.
- `valid` low: pipeline registers still advance, FSM holds its state, and `valid_pixel` = 0 after 2 cycles.
- Frame start coinciding with a `read_index` toggle: the new value is latched; there is no 1-frame lag.
- `sample_idx` wrap from 255 to 0 only occurs on a new row. The FSM passes through OUTSIDE, so FIRST reseeds `prev_s`.

## Structure
- Shared package/header holds:
  - state encodings (one-hot, 3 bits): `OUTSIDE` 3'b100, `FIRST` 3'b010, `DRAW` 3'b001;
  - window constants: width 512, height 512.
- All registers use the codebase `dff`/`dffr`/`dffre` primitives.
- One natural sub-module, `wave_pixel_test`: combinational (`ry`, `prev_s`, `curr_s`, `active`) → `lit`, including the min/max ordering.

## Test plan
- **Reset:** hold `reset` 3 cycles with `valid` = 1 → `r`/`g`/`b` = 0, `valid_pixel` = 0, `wave_display_idle` = 1.
- **Latency and address:**
  - Drive `x` = 256, `y` = 10 at cycle t → `read_address` = {`display_half`, 8'd0} at t.
  - Drive `x` = 258 → index 1.
  - The pixel for that coordinate appears at t+2.
- **Flat trace:**
  - RAM filled with 8'd128 → only row `ry` = 127 (`y` = 254, 255) is lit across `x` = 256..767.
  - Pixels at `x` = 255 and `x` = 768 are black.
- **Line fill:**
  - Samples 0 = 8'd255 and 1 = 8'd0 → at `x` = 258/259, rows `ry` 0..255 are all lit.
  - At `x` = 256 (FIRST), only `ry` = 0 is lit.
- **Buffer swap:**
  - Toggle `read_index` mid-frame (`y` = 100) → `read_address`[8] is unchanged until the next `x` = 0, `y` = 0, then follows the new value.
- **Idle and mid-frame reset:**
  - `y` = 511 → 512 → `wave_display_idle` rises one cycle later.
  - Reset asserted at `y` = 200 → the output is black the next cycle and the trace is redrawn from the next window entry.

Source files
------------

// File: rtl/wave_display_render_pkg.sv
// Shared constants for the waveform display renderer: line FSM encodings,
// window geometry and the sample-to-row mapping.
package wave_display_render_pkg;

    localparam logic [2:0] OUTSIDE = 3'b100;
    localparam logic [2:0] FIRST   = 3'b010;
    localparam logic [2:0] DRAW    = 3'b001;

    localparam logic [10:0] WIN_W = 11'd512;
    localparam logic [9:0]  WIN_H = 10'd512;

    // Offset-binary sample to screen row: the largest value lands on row 0.
    function automatic logic [7:0] sample_row(input logic [7:0] s);
        return 8'd255 - s;
    endfunction

endpackage

// File: rtl/dff.sv
// Register primitives: plain, synchronously resettable, and resettable with
// load enable. Reset is synchronous and active-high.
module dff #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // Plain register.
    always_ff @(posedge i_clk) begin
        o_q <= i_d;
    end
endmodule

module dffr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // Register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q <= RST_VAL;
        end else begin
            o_q <= i_d;
        end
    end
endmodule

module dffre #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // Register with synchronous reset and load enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end else begin
            o_q <= o_q;
        end
    end
endmodule

// File: rtl/wave_display_render_pixel_test.sv
// Decides whether a pixel row falls on the vertical segment joining the
// previous and current samples.
module wave_pixel_test
    import wave_display_render_pkg::*;
(
    input  logic [7:0] i_ry,
    input  logic [7:0] i_prev_s,
    input  logic [7:0] i_curr_s,
    input  logic       i_active,
    output logic       o_lit
);
    logic [7:0] w_p;
    logic [7:0] w_c;
    logic [7:0] w_lo;
    logic [7:0] w_hi;

    assign w_p = sample_row(i_prev_s);
    assign w_c = sample_row(i_curr_s);

    // Order the segment end points so the range test is a simple bracket.
    always_comb begin
        w_lo = w_p;
        w_hi = w_c;
        if (w_p <= w_c) begin
            w_lo = w_p;
            w_hi = w_c;
        end else begin
            w_lo = w_c;
            w_hi = w_p;
        end
    end

    assign o_lit = i_active && (i_ry >= w_lo) && (i_ry <= w_hi);

endmodule

// File: rtl/wave_display_render.sv
// Renders the displayed half of the waveform sample RAM as a connected trace
// inside a 512x512 window; two-cycle pipeline from coordinates to colour.
module wave_display_render
    import wave_display_render_pkg::*;
#(
    parameter logic [10:0] X_START   = 11'd256,
    parameter logic [23:0] TRACE_RGB = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);
    logic [10:0] w_dx;
    logic [7:0]  w_idx0;
    logic        w_in_win0;
    logic        w_frame_start;
    logic        w_unused;
    logic        r_display_half;

    logic        r_valid1;
    logic        r_in_win1;
    logic [7:0]  r_ry1;
    logic [7:0]  r_idx1;

    logic [2:0]  r_state;
    logic [7:0]  r_prev_s;
    logic [7:0]  r_curr_s;
    logic [7:0]  r_last_idx;
    logic [2:0]  w_state_nxt;
    logic [7:0]  w_prev_nxt;
    logic [7:0]  w_curr_nxt;
    logic [7:0]  w_last_idx_nxt;

    logic        w_lit;
    logic [23:0] w_rgb_nxt;
    logic [23:0] r_rgb;

    // Stage 0: window test and RAM address.
    assign w_dx          = x - X_START;
    assign w_idx0        = w_dx[8:1];
    assign w_in_win0     = valid && (x >= X_START) && (w_dx < WIN_W) && (y < WIN_H);
    assign w_frame_start = valid && (x == 11'd0) && (y == 10'd0);
    assign read_address  = {r_display_half, w_idx0};
    assign w_unused      = ^{y[0], w_dx[0]};

    // The displayed half only changes at frame start so a frame never tears.
    dffre #(.W(1), .RST_VAL(1'b0)) u_half (
        .i_clk(clk), .i_reset(reset), .i_en(w_frame_start),
        .i_d(read_index), .o_q(r_display_half)
    );

    dffr #(.W(1), .RST_VAL(1'b0)) u_valid1 (
        .i_clk(clk), .i_reset(reset), .i_d(valid), .o_q(r_valid1)
    );
    dffr #(.W(1), .RST_VAL(1'b0)) u_in_win1 (
        .i_clk(clk), .i_reset(reset), .i_d(w_in_win0), .o_q(r_in_win1)
    );
    dff #(.W(8)) u_ry1  (.i_clk(clk), .i_d(y[8:1]), .o_q(r_ry1));
    dff #(.W(8)) u_idx1 (.i_clk(clk), .i_d(w_idx0), .o_q(r_idx1));

    // Stage 1 line FSM; the updated sample pair is used for this pixel.
    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev_s;
        w_curr_nxt     = r_curr_s;
        w_last_idx_nxt = r_last_idx;
        if (r_valid1) begin
            w_last_idx_nxt = r_idx1;
            if (!r_in_win1) begin
                w_state_nxt = OUTSIDE;
            end else begin
                case (r_state)
                    OUTSIDE: begin
                        w_state_nxt = FIRST;
                        w_prev_nxt  = read_value;
                        w_curr_nxt  = read_value;
                    end
                    FIRST, DRAW: begin
                        w_state_nxt = DRAW;
                        if (r_idx1 != r_last_idx) begin
                            w_prev_nxt = r_curr_s;
                            w_curr_nxt = read_value;
                        end else begin
                            w_prev_nxt = r_prev_s;
                            w_curr_nxt = r_curr_s;
                        end
                    end
                    default: begin
                        w_state_nxt = OUTSIDE;
                    end
                endcase
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    dffr #(.W(3), .RST_VAL(OUTSIDE)) u_state (
        .i_clk(clk), .i_reset(reset), .i_d(w_state_nxt), .o_q(r_state)
    );
    dffr #(.W(8), .RST_VAL(8'd128)) u_prev (
        .i_clk(clk), .i_reset(reset), .i_d(w_prev_nxt), .o_q(r_prev_s)
    );
    dffr #(.W(8), .RST_VAL(8'd128)) u_curr (
        .i_clk(clk), .i_reset(reset), .i_d(w_curr_nxt), .o_q(r_curr_s)
    );
    dffr #(.W(8), .RST_VAL(8'd0)) u_last_idx (
        .i_clk(clk), .i_reset(reset), .i_d(w_last_idx_nxt), .o_q(r_last_idx)
    );

    wave_pixel_test u_pixel_test (
        .i_ry(r_ry1),
        .i_prev_s(w_prev_nxt),
        .i_curr_s(w_curr_nxt),
        .i_active(r_valid1 && (w_state_nxt != OUTSIDE)),
        .o_lit(w_lit)
    );

    assign w_rgb_nxt = w_lit ? TRACE_RGB : 24'h000000;

    // Stage 2: registered colour, pixel strobe and idle flag.
    dffr #(.W(24), .RST_VAL(24'h000000)) u_rgb (
        .i_clk(clk), .i_reset(reset), .i_d(w_rgb_nxt), .o_q(r_rgb)
    );
    dffr #(.W(1), .RST_VAL(1'b0)) u_vp (
        .i_clk(clk), .i_reset(reset), .i_d(r_valid1), .o_q(valid_pixel)
    );
    dffr #(.W(1), .RST_VAL(1'b1)) u_idle (
        .i_clk(clk), .i_reset(reset), .i_d(y[9]), .o_q(wave_display_idle)
    );

    assign {r, g, b} = r_rgb;

endmodule

// File: tb/tb_wave_display_render.sv
// Scoreboard bench for wave_display_render: directed pixels push expected
// colour and issue cycle; a negedge monitor pops on every valid_pixel.
module tb_wave_display_render;
    logic        clk;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        valid_pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        wave_display_idle;

    logic [7:0] ram [512];
    logic       exp_q [$];
    int         cyc_q [$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       exp_half = 1'b0;
    int         lf_rows [8] = '{0, 1, 100, 254, 255, 300, 510, 511};

    wave_display_render dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
        .read_index(read_index), .read_value(read_value),
        .read_address(read_address), .valid_pixel(valid_pixel),
        .r(r), .g(g), .b(b), .wave_display_idle(wave_display_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        read_value <= ram[read_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic ex;
        int   c0;
        if (valid_pixel === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pixel: got a pixel, required none (cycle %0d)", cyc);
            end else begin
                ex = exp_q.pop_front();
                c0 = cyc_q.pop_front();
                chk("latency", 32'(cyc - c0), 32'd2);
                chk("rgb", {8'h00, r, g, b}, ex ? 32'h00FFFFFF : 32'h00000000);
            end
        end
    end

    task automatic px(input logic [10:0] xi, input logic [9:0] yi, input logic ex);
        logic [10:0] dx;
        x = xi;
        y = yi;
        valid = 1'b1;
        dx = xi - 11'd256;
        #1;
        chk("read_address", 32'(read_address), 32'({exp_half, dx[8:1]}));
        exp_q.push_back(ex);
        cyc_q.push_back(cyc);
        @(posedge clk);
        #1;
        if (xi == 11'd0 && yi == 10'd0) exp_half = read_index;
    endtask

    task automatic gap(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n, input logic [10:0] xi, input logic [9:0] yi);
        reset = 1'b1;
        valid = 1'b1;
        x = xi;
        y = yi;
        repeat (n) @(posedge clk);
        #1;
        exp_q.delete();
        cyc_q.delete();
        chk("reset_rgb", {8'h00, r, g, b}, 32'h0);
        chk("reset_valid_pixel", 32'(valid_pixel), 32'd0);
        chk("reset_idle", 32'(wave_display_idle), 32'd1);
        exp_half = 1'b0;
        reset = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        valid = 1'b1;
        x = 11'd0;
        y = 10'd0;
        read_index = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = 8'd128;

        do_reset(3, 11'd0, 10'd0);

        // Latency and address of the first two samples.
        px(11'd256, 10'd10, 1'b0);
        px(11'd258, 10'd10, 1'b0);
        gap(3);

        // Flat trace at 128: only ry = 127 lit, with a valid gap mid-row.
        for (int yy = 253; yy <= 256; yy++) begin
            for (int xx = 255; xx <= 768; xx++) begin
                if (xx == 500) gap(3);
                px(11'(xx), 10'(yy), (yy == 254 || yy == 255) && xx >= 256 && xx <= 767);
            end
            gap(2);
        end

        // Line fill: samples 255, 0, 128.
        ram[0] = 8'd255;
        ram[1] = 8'd0;
        for (int k = 0; k < 8; k++) begin
            px(11'd255, 10'(lf_rows[k]), 1'b0);
            px(11'd256, 10'(lf_rows[k]), (lf_rows[k] / 2) == 0);
            px(11'd257, 10'(lf_rows[k]), (lf_rows[k] / 2) == 0);
            px(11'd258, 10'(lf_rows[k]), 1'b1);
            gap(1);
            px(11'd259, 10'(lf_rows[k]), 1'b1);
            px(11'd260, 10'(lf_rows[k]), (lf_rows[k] / 2) >= 127);
            px(11'd261, 10'(lf_rows[k]), (lf_rows[k] / 2) >= 127);
        end
        px(11'd256, 10'd512, 1'b0);
        ram[0] = 8'd128;
        ram[1] = 8'd128;

        // Idle flag follows y[9] one cycle later, regardless of valid.
        px(11'd255, 10'd511, 1'b0);
        px(11'd300, 10'd511, 1'b0);
        chk("idle_row511", 32'(wave_display_idle), 32'd0);
        px(11'd300, 10'd512, 1'b0);
        chk("idle_row512", 32'(wave_display_idle), 32'd1);
        y = 10'd100;
        gap(1);
        chk("idle_invalid_row100", 32'(wave_display_idle), 32'd0);

        // Buffer swap: half 1 holds all-zero samples.
        for (int i = 256; i < 512; i++) ram[i] = 8'd0;
        read_index = 1'b0;
        px(11'd0, 10'd0, 1'b0);
        px(11'd255, 10'd100, 1'b0);
        px(11'd300, 10'd100, 1'b0);
        read_index = 1'b1;
        px(11'd255, 10'd254, 1'b0);
        px(11'd300, 10'd254, 1'b1);
        px(11'd0, 10'd0, 1'b0);
        px(11'd255, 10'd510, 1'b0);
        px(11'd300, 10'd510, 1'b1);
        px(11'd255, 10'd254, 1'b0);
        px(11'd300, 10'd254, 1'b0);
        read_index = 1'b0;
        px(11'd0, 10'd0, 1'b0);
        px(11'd255, 10'd254, 1'b0);
        px(11'd300, 10'd254, 1'b1);
        gap(2);

        // Mid-frame reset while drawing from half 1.
        for (int i = 256; i < 512; i++) ram[i] = 8'd155;
        read_index = 1'b1;
        px(11'd0, 10'd0, 1'b0);
        px(11'd255, 10'd200, 1'b0);
        for (int xx = 256; xx <= 259; xx++) px(11'(xx), 10'd200, 1'b1);
        do_reset(1, 11'd260, 10'd200);
        px(11'd255, 10'd200, 1'b0);
        px(11'd256, 10'd200, 1'b0);
        px(11'd255, 10'd254, 1'b0);
        for (int xx = 256; xx <= 259; xx++) px(11'(xx), 10'd254, 1'b1);

        gap(4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
